// File: rtl/tree_input_ctrl_buf.sv
// Buffered input controller for one binary-tree NoC router port: FIFO plus
// three-way prefix route (up / lo / hi) with illegal self-addressed packets dropped and counted.
module tree_input_ctrl_buf #(
  parameter int unsigned WIDTH_packet = 14,
  parameter int unsigned WIDTH_addr   = 3,
  parameter int unsigned WIDTH_dest   = 3,
  parameter int unsigned LEVEL        = 0,
  parameter int unsigned PREFIX       = 0,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [WIDTH_packet-1:0] i_in_data,
  output logic                    o_up_valid,
  input  logic                    i_up_ready,
  output logic                    o_lo_valid,
  input  logic                    i_lo_ready,
  output logic                    o_hi_valid,
  input  logic                    i_hi_ready,
  output logic [WIDTH_packet-1:0] o_out_data,
  output logic [$clog2(DEPTH):0]  o_occupancy,
  output logic [CNT_W-1:0]        o_drop_cnt
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  // Top LEVEL bits of dest must equal the low LEVEL bits of PREFIX; empty mask at the root.
  localparam int unsigned MaskInt  = ((32'd1 << LEVEL) - 32'd1) << (WIDTH_dest - LEVEL);
  localparam int unsigned PrefInt  = (PREFIX << (WIDTH_dest - LEVEL)) & MaskInt;
  localparam logic [WIDTH_dest-1:0] PrefMask = WIDTH_dest'(MaskInt);
  localparam logic [WIDTH_dest-1:0] PrefVal  = WIDTH_dest'(PrefInt);
  localparam int unsigned RouteBit = WIDTH_dest - 1 - LEVEL;

  logic [WIDTH_packet-1:0] r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [CNT_W-1:0]        r_drop_cnt;

  logic [WIDTH_packet-1:0] w_head;
  logic [WIDTH_addr-1:0]   w_src;
  logic [WIDTH_dest-1:0]   w_dest;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_illegal;
  logic                    w_mismatch;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;

  assign w_head     = r_mem[r_rd_ptr];
  assign w_src      = w_head[WIDTH_packet-1 -: WIDTH_addr];
  assign w_dest     = w_head[WIDTH_packet-1-WIDTH_addr -: WIDTH_dest];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_illegal  = (w_dest == w_src);
  assign w_mismatch = (((w_dest ^ PrefVal) & PrefMask) != '0);

  always_comb begin
    o_up_valid = 1'b0;
    o_lo_valid = 1'b0;
    o_hi_valid = 1'b0;
    if (!w_empty && !w_illegal) begin
      if (w_mismatch) begin
        o_up_valid = 1'b1;
      end else if (w_dest[RouteBit]) begin
        o_hi_valid = 1'b1;
      end else begin
        o_lo_valid = 1'b1;
      end
    end
  end

  // Illegal heads never raise a valid; they are discarded one per cycle.
  assign w_drop = !w_empty && w_illegal;
  assign w_pop  = (o_up_valid && i_up_ready) || (o_lo_valid && i_lo_ready) ||
                  (o_hi_valid && i_hi_ready) || w_drop;

  assign o_in_ready  = i_rst_n && !w_full;
  assign w_push      = i_in_valid && o_in_ready;
  assign o_out_data  = w_head;
  assign o_occupancy = r_count;
  assign o_drop_cnt  = r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

endmodule
